writeback_stage: RTL and testbench



---
 rtl/writeback_stage.sv | 160 ++++++++++++++++
 tb/tb_writeback_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : SEQ RISC-V writeback; picks ALU or formatted load data and
//               drives the register-file write port. Optional retired-
//               instruction counter enabled by defining WB_INSTRET_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_reg_write,
    input  logic            in_mem_to_reg,
    input  logic            in_mem_read,
    input  logic [2:0]      in_funct3,
    input  logic [2:0]      in_addr_low,
    input  logic [XLEN-1:0] alu_result,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            reg_write,
    output logic            retire,
    output logic [63:0]     instret
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_WRITE    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;

    logic [4:0]        r_hold_rd;
    logic              r_hold_we;
    logic              r_hold_m2r;
    logic [2:0]        r_hold_f3;
    logic [2:0]        r_hold_lo;
    logic [XLEN-1:0]   r_hold_alu;

    logic [4:0]        r_rd_addr;
    logic [XLEN-1:0]   r_rd_data;
    logic              r_wr_en;

    logic [XLEN-1:0]   w_shift;
    logic [XLEN-1:0]   w_load_fmt;

    assign in_ready = (r_state != S_WAIT_MEM);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = in_mem_read ? S_WAIT_MEM : S_WRITE;
                end
            end
            S_WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_accept) begin
                    w_state_next = in_mem_read ? S_WAIT_MEM : S_WRITE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Byte-lane shift zero-fills from the top, so misaligned tails read as zero
    assign w_shift = mem_rsp_data >> {r_hold_lo, 3'b000};

    always_comb begin
        w_load_fmt = w_shift;
        case (r_hold_f3)
            3'b000:  w_load_fmt = {{(XLEN-8){w_shift[7]}},   w_shift[7:0]};
            3'b001:  w_load_fmt = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_load_fmt = {{(XLEN-32){w_shift[31]}}, w_shift[31:0]};
            3'b100:  w_load_fmt = {{(XLEN-8){1'b0}},         w_shift[7:0]};
            3'b101:  w_load_fmt = {{(XLEN-16){1'b0}},        w_shift[15:0]};
            3'b110:  w_load_fmt = {{(XLEN-32){1'b0}},        w_shift[31:0]};
            default: w_load_fmt = w_shift;
        endcase
    end

    // Output registers only change when an instruction enters WRITE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold_rd  <= '0;
            r_hold_we  <= 1'b0;
            r_hold_m2r <= 1'b0;
            r_hold_f3  <= '0;
            r_hold_lo  <= '0;
            r_hold_alu <= '0;
            r_rd_addr  <= '0;
            r_rd_data  <= '0;
            r_wr_en    <= 1'b0;
        end else if (w_accept) begin
            r_hold_rd  <= in_rd_addr;
            r_hold_we  <= in_reg_write;
            r_hold_m2r <= in_mem_to_reg;
            r_hold_f3  <= in_funct3;
            r_hold_lo  <= in_addr_low;
            r_hold_alu <= alu_result;
            if (!in_mem_read) begin
                r_rd_addr <= in_rd_addr;
                r_rd_data <= alu_result;
                r_wr_en   <= in_reg_write;
            end
        end else if ((r_state == S_WAIT_MEM) && mem_rsp_valid) begin
            r_rd_addr <= r_hold_rd;
            r_rd_data <= r_hold_m2r ? w_load_fmt : r_hold_alu;
            r_wr_en   <= r_hold_we;
        end
    end

    assign rd_addr   = r_rd_addr;
    assign rd_data   = r_rd_data;
    assign retire    = (r_state == S_WRITE);
    assign reg_write = (r_state == S_WRITE) && r_wr_en && (r_rd_addr != 5'd0);

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instret <= '0;
        end else if (r_state == S_WRITE) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`else
    assign instret = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed self-checking bench for writeback_stage with a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd_addr;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic        in_mem_read;
    logic [2:0]  in_funct3;
    logic [2:0]  in_addr_low;
    logic [63:0] alu_result;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        reg_write;
    logic        retire;
    logic [63:0] instret;

    int n_checks = 0;
    int n_errors = 0;

    writeback_stage #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
        .in_mem_to_reg(in_mem_to_reg), .in_mem_read(in_mem_read),
        .in_funct3(in_funct3), .in_addr_low(in_addr_low),
        .alu_result(alu_result),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write),
        .retire(retire), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Load result from byte-level rules: pick bytes, then extend to 64 bits
    function automatic logic [63:0] fmt_load(input logic [63:0] d, input logic [2:0] f3,
                                             input logic [2:0] lo);
        logic [7:0]  b [8];
        logic [63:0] r;
        logic        s;
        int          nbytes;
        for (int i = 0; i < 8; i++)
            b[i] = (i + int'(lo) < 8) ? d[8*(i+int'(lo)) +: 8] : 8'h00;
        case (f3[1:0])
            2'd0:    nbytes = 1;
            2'd1:    nbytes = 2;
            2'd2:    nbytes = 4;
            default: nbytes = 8;
        endcase
        r = '0;
        for (int i = 0; i < nbytes; i++) r[8*i +: 8] = b[i];
        s = !f3[2] && r[8*nbytes-1];
        for (int i = nbytes; i < 8; i++) r[8*i +: 8] = {8{s}};
        return r;
    endfunction

    // Reference model: one in-flight instruction, either awaiting data or writing
    logic        m_waiting = 1'b0;
    logic        m_writing = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [63:0] m_data = '0;
    logic        m_we = 1'b0;
    logic [63:0] m_instret = '0;
    logic [4:0]  p_rd;
    logic        p_we, p_m2r;
    logic [2:0]  p_f3, p_lo;
    logic [63:0] p_alu;

    always @(posedge clk) begin
        logic can_take, next_writing;
        if (!rst) begin
            m_waiting = 1'b0; m_writing = 1'b0;
            m_rd = '0; m_data = '0; m_we = 1'b0; m_instret = '0;
        end else begin
            can_take = !m_waiting;
`ifdef WB_INSTRET_EN
            if (m_writing) m_instret = m_instret + 64'd1;
`endif
            next_writing = 1'b0;
            if (m_waiting && mem_rsp_valid) begin
                m_waiting = 1'b0;
                next_writing = 1'b1;
                m_rd = p_rd;
                m_we = p_we;
                m_data = p_m2r ? fmt_load(mem_rsp_data, p_f3, p_lo) : p_alu;
            end
            if (can_take && in_valid) begin
                p_rd = in_rd_addr; p_we = in_reg_write; p_m2r = in_mem_to_reg;
                p_f3 = in_funct3; p_lo = in_addr_low; p_alu = alu_result;
                if (in_mem_read) begin
                    m_waiting = 1'b1;
                end else begin
                    next_writing = 1'b1;
                    m_rd = in_rd_addr; m_we = in_reg_write; m_data = alu_result;
                end
            end
            m_writing = next_writing;
        end
    end

    always @(posedge clk) begin
        #1;
        check("cmp_in_ready",  64'(in_ready), 64'(!m_waiting));
        check("cmp_retire",    64'(retire),   64'(m_writing));
        check("cmp_reg_write", 64'(reg_write), 64'(m_writing && m_we && (m_rd != 5'd0)));
        check("cmp_rd_addr",   64'(rd_addr),  64'(m_rd));
        check("cmp_rd_data",   rd_data,       m_data);
        check("cmp_instret",   instret,       m_instret);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] rd, input logic we, input logic m2r,
                          input logic mr, input logic [2:0] f3, input logic [2:0] lo,
                          input logic [63:0] alu);
        in_valid = 1'b1; in_rd_addr = rd; in_reg_write = we; in_mem_to_reg = m2r;
        in_mem_read = mr; in_funct3 = f3; in_addr_low = lo; alu_result = alu;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] lo,
                           input logic m2r, input logic [63:0] alu, input logic [63:0] data,
                           input int gap, input logic [63:0] exp);
        set_op(rd, 1'b1, m2r, 1'b1, f3, lo, alu);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            check("ld_wait_ready", 64'(in_ready), 64'd0);
            tick();
        end
        check("ld_wait_ready", 64'(in_ready), 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        check("ld_data",    rd_data,          exp);
        check("ld_we",      64'(reg_write),   64'd1);
        check("ld_rd_addr", 64'(rd_addr),     64'(rd));
        tick();
    endtask

    initial begin
        logic [63:0] exp_cnt;
        rst = 1'b0; in_valid = 1'b0; in_rd_addr = '0; in_reg_write = 1'b0;
        in_mem_to_reg = 1'b0; in_mem_read = 1'b0; in_funct3 = '0; in_addr_low = '0;
        alu_result = '0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        tick();
        tick();
        check("rst_ready",   64'(in_ready),  64'd1);
        check("rst_we",      64'(reg_write), 64'd0);
        check("rst_retire",  64'(retire),    64'd0);
        check("rst_data",    rd_data,        64'd0);
        check("rst_instret", instret,        64'd0);
        rst = 1'b1;

        // Back-to-back non-loads, first to x0
        set_op(5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 64'h11);
        tick();
        check("b2b0_we",  64'(reg_write), 64'd0);
        check("b2b0_ret", 64'(retire),    64'd1);
        set_op(5'd7, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 64'h22);
        tick();
        check("b2b1_we",   64'(reg_write), 64'd1);
        check("b2b1_rd",   64'(rd_addr),   64'd7);
        check("b2b1_data", rd_data,        64'h22);
        set_op(5'd8, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 64'h33);
        tick();
        check("b2b2_we", 64'(reg_write), 64'd1);
        check("b2b2_rd", 64'(rd_addr),   64'd8);
        in_valid = 1'b0;
        tick();
        check("b2b_idle_ret", 64'(retire), 64'd0);
`ifdef WB_INSTRET_EN
        exp_cnt = 64'd3;
`else
        exp_cnt = 64'd0;
`endif
        check("b2b_instret", instret, exp_cnt);

        set_op(5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 64'h1234);
        tick();
        in_valid = 1'b0;
        check("alu_we",   64'(reg_write), 64'd1);
        check("alu_rd",   64'(rd_addr),   64'd5);
        check("alu_data", rd_data,        64'h1234);
        check("alu_ret",  64'(retire),    64'd1);
        tick();

        // Stray response in IDLE is ignored and outputs hold
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_rsp_valid = 1'b0;
        check("stray_we",   64'(reg_write), 64'd0);
        check("stray_data", rd_data,        64'h1234);
        check("stray_rd",   64'(rd_addr),   64'd5);

        do_load(5'd10, 3'b000, 3'd3, 1'b1, 64'h0, 64'h0000_0000_8000_0000, 1, 64'hFFFF_FFFF_FFFF_FF80);
        do_load(5'd11, 3'b101, 3'd4, 1'b1, 64'h0, 64'hDEAD_BEEF_0000_0000, 0, 64'h0000_0000_0000_BEEF);
        do_load(5'd12, 3'b110, 3'd4, 1'b1, 64'h0, 64'hDEAD_BEEF_0000_0000, 0, 64'h0000_0000_DEAD_BEEF);
        do_load(5'd13, 3'b011, 3'd0, 1'b1, 64'h0, 64'hDEAD_BEEF_0000_0000, 2, 64'hDEAD_BEEF_0000_0000);
        do_load(5'd14, 3'b001, 3'd6, 1'b1, 64'h0, 64'h8000_0000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_8000);
        do_load(5'd15, 3'b011, 3'd5, 1'b1, 64'h0, 64'h1122_3344_5566_7788, 0, 64'h0000_0000_0011_2233);
        do_load(5'd16, 3'b111, 3'd0, 1'b1, 64'h0, 64'hCAFE_F00D_1234_5678, 0, 64'hCAFE_F00D_1234_5678);
        do_load(5'd17, 3'b010, 3'd0, 1'b1, 64'h0, 64'h0000_0000_F000_0001, 0, 64'hFFFF_FFFF_F000_0001);
        do_load(5'd18, 3'b000, 3'd0, 1'b0, 64'hABCD, 64'h5555_5555_5555_5555, 1, 64'h0000_0000_0000_ABCD);
        do_load(5'd19, 3'b100, 3'd7, 1'b1, 64'h0, 64'hFF00_0000_0000_0000, 0, 64'h0000_0000_0000_00FF);

        // Load whose WRITE cycle overlaps a new non-load accept
        set_op(5'd21, 1'b1, 1'b1, 1'b1, 3'b100, 3'd1, 64'h0);
        tick();
        in_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0000_0000_0000_A500;
        tick();
        mem_rsp_valid = 1'b0;
        check("ovl_ld_data", rd_data, 64'hA5);
        set_op(5'd22, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 64'h77);
        tick();
        in_valid = 1'b0;
        check("ovl_alu_data", rd_data, 64'h77);
        check("ovl_alu_we",   64'(reg_write), 64'd1);
        tick();

        // Reset while waiting for load data drops the instruction
        set_op(5'd20, 1'b1, 1'b1, 1'b1, 3'b011, 3'd0, 64'h0);
        tick();
        in_valid = 1'b0;
        check("rl_wait_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_rsp_valid = 1'b0;
        check("rl_we",      64'(reg_write), 64'd0);
        check("rl_ready",   64'(in_ready),  64'd1);
        check("rl_rd",      64'(rd_addr),   64'd0);
        check("rl_data",    rd_data,        64'd0);
        check("rl_ret",     64'(retire),    64'd0);
        check("rl_instret", instret,        64'd0);
        tick();
        check("rl_we2", 64'(reg_write), 64'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
